// File: rtl/graph_loader.sv
// Edge-stream loader for pageRank: builds the N x N adjacency matrix, counts out-degrees,
// then computes per-node weights 1/outdeg in Q0.WIDTH with a fixed-latency restoring divider.
module graph_loader #(
   parameter int unsigned N     = 16,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               edge_valid_i,
   output logic               edge_ready_o,
   input  logic [IW-1:0]      edge_src_i,
   input  logic [IW-1:0]      edge_dst_i,
   input  logic               edge_last_i,
   output logic [N*N-1:0]     adjacency_o,
   output logic [N*WIDTH-1:0] weights_o,
   output logic               graph_valid_o,
   output logic               busy_o
);

   localparam int unsigned AW       = (N > 1) ? $clog2(N * N) : 1;
   localparam int unsigned CW       = $clog2(WIDTH + 1);
   localparam int unsigned RW       = IW + 2;
   localparam logic [CW-1:0] LastCyc  = CW'(WIDTH);
   localparam logic [CW-1:0] CycOne   = CW'(1);
   localparam logic [IW-1:0] LastNode = IW'(N - 1);
   localparam logic [IW-1:0] NodeOne  = IW'(1);
   localparam logic [IW:0]   DegOne   = (IW + 1)'(1);
   localparam logic [RW-1:0] RemOne   = RW'(1);

   typedef enum logic [1:0] {StLoad, StDiv, StDone} state_e;

   state_e             state_q, state_d;
   logic [N*N-1:0]     adj_q;
   logic [N*WIDTH-1:0] weights_q;
   logic [IW:0]        deg_q [N];
   logic [IW-1:0]      node_q;
   logic [CW-1:0]      cyc_q;
   logic [RW-1:0]      rem_q;
   logic [WIDTH-1:0]   quo_q;

   logic               hs, in_range, store;
   logic [AW-1:0]      idx;
   logic [RW-1:0]      divisor, rem_sh, rem_step;
   logic               ge;
   logic [WIDTH-1:0]   quo_step, wval;

   assign hs = edge_valid_i && edge_ready_o;

   always_comb begin
      idx      = AW'(32'(edge_dst_i) * N + 32'(edge_src_i));
      in_range = (32'(edge_src_i) < N) && (32'(edge_dst_i) < N);
      store    = in_range && (edge_src_i != edge_dst_i) && !adj_q[idx];
   end

   // Dividend 2^WIDTH is modelled by starting the remainder at 1 and shifting in zeros.
   always_comb begin
      divisor  = RW'(deg_q[node_q]);
      rem_sh   = rem_q << 1;
      ge       = (rem_sh >= divisor);
      rem_step = ge ? (rem_sh - divisor) : rem_sh;
      quo_step = (quo_q << 1) | WIDTH'(ge);
      if (deg_q[node_q] == '0) begin
         wval = '0;
      end else if (deg_q[node_q] == DegOne) begin
         wval = '1;
      end else begin
         wval = quo_step;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = StLoad;
      end else begin
         case (state_q)
            StLoad:  if (hs && edge_last_i) state_d = StDiv;
            StDiv:   if (node_q == LastNode && cyc_q == LastCyc) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StLoad;
         endcase
      end
   end

   always_comb begin
      edge_ready_o  = (state_q == StLoad) && !clear_i;
      busy_o        = (state_q == StDiv);
      graph_valid_o = (state_q == StDone);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adj_q     <= '0;
         weights_q <= '0;
         node_q    <= '0;
         cyc_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         for (int i = 0; i < N; i++) deg_q[i] <= '0;
      end else if (clear_i) begin
         adj_q     <= '0;
         weights_q <= '0;
         node_q    <= '0;
         cyc_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         for (int i = 0; i < N; i++) deg_q[i] <= '0;
      end else if (state_q == StLoad) begin
         node_q <= '0;
         cyc_q  <= '0;
         if (hs && store) begin
            adj_q[idx]         <= 1'b1;
            deg_q[edge_src_i]  <= deg_q[edge_src_i] + DegOne;
         end
      end else if (state_q == StDiv) begin
         if (cyc_q == '0) begin
            rem_q <= RemOne;
            quo_q <= '0;
            cyc_q <= CycOne;
         end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            if (cyc_q == LastCyc) begin
               for (int k = 0; k < N; k++) begin
                  if (node_q == IW'(k)) weights_q[k*WIDTH +: WIDTH] <= wval;
               end
               cyc_q  <= '0;
               node_q <= node_q + NodeOne;
            end else begin
               cyc_q <= cyc_q + CycOne;
            end
         end
      end
   end

   assign adjacency_o = adj_q;
   assign weights_o   = weights_q;

endmodule

// File: tb/tb_graph_loader.sv
// Self-checking bench for graph_loader: directed scenarios plus random graphs on an N=4
// instance against a set/degree reference model, and one fan-out graph on a default N=16 instance.
module tb_graph_loader;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 16;
   localparam int unsigned N16 = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic          clear, ev, er, el, gv, busy;
   logic [1:0]    es, ed;
   logic [N*N-1:0] adj;
   logic [N*W-1:0] w;

   logic            clear16, ev16, er16, el16, gv16, busy16;
   logic [3:0]      es16, ed16;
   logic [N16*N16-1:0] adj16;
   logic [N16*W-1:0]   w16;

   int total = 0;
   int bad   = 0;

   bit m_adj [N*N];
   int m_deg [N];

   always #5 clk = ~clk;

   graph_loader #(.N(N), .WIDTH(W)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear),
      .edge_valid_i (ev),
      .edge_ready_o (er),
      .edge_src_i   (es),
      .edge_dst_i   (ed),
      .edge_last_i  (el),
      .adjacency_o  (adj),
      .weights_o    (w),
      .graph_valid_o(gv),
      .busy_o       (busy)
   );

   graph_loader u_dut16 (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear16),
      .edge_valid_i (ev16),
      .edge_ready_o (er16),
      .edge_src_i   (es16),
      .edge_dst_i   (ed16),
      .edge_last_i  (el16),
      .adjacency_o  (adj16),
      .weights_o    (w16),
      .graph_valid_o(gv16),
      .busy_o       (busy16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N*N; i++) m_adj[i] = 1'b0;
      for (int i = 0; i < N; i++) m_deg[i] = 0;
   endtask

   function automatic logic [15:0] wexp(input int d);
      if (d == 0) return 16'h0000;
      if (d == 1) return 16'hFFFF;
      return 16'((32'h10000) / d);
   endfunction

   // Present one edge after 'gap' idle cycles; returns right at the accepting edge.
   task automatic send(input int s, input int d, input bit last, input int gap);
      logic rdy;
      @(negedge clk);
      ev = 1'b0;
      repeat (gap) @(negedge clk);
      es = 2'(s);
      ed = 2'(d);
      el = last;
      ev = 1'b1;
      #1;
      rdy = er;
      check("load_ready", rdy, 1);
      @(posedge clk);
      if (rdy && s != d && !m_adj[d*N+s]) begin
         m_adj[d*N+s] = 1'b1;
         m_deg[s]++;
      end
   endtask

   // Called right at the last-handshake edge; optionally keeps offering an edge throughout.
   task automatic wait_valid(input bit hold);
      int cnt = 0, busy_cnt = 0, rdy_cnt = 0;
      #1;
      ev = hold;
      es = 2'd1;
      ed = 2'd0;
      el = 1'b0;
      do begin
         if (busy) busy_cnt++;
         if (er) rdy_cnt++;
         @(posedge clk);
         #1;
         cnt++;
      end while (!gv && cnt < 2000);
      check("latency", cnt, N*(W+1));
      check("busy_cycles", busy_cnt, N*(W+1));
      repeat (4) begin
         @(posedge clk);
         #1;
         if (er || busy || !gv) rdy_cnt++;
      end
      check("div_done_blocked", rdy_cnt, 0);
      ev = 1'b0;
   endtask

   task automatic check_graph();
      logic [N*N-1:0] ea;
      for (int i = 0; i < N*N; i++) ea[i] = m_adj[i];
      check("adjacency", adj, ea);
      for (int k = 0; k < N; k++) check($sformatf("weight%0d", k), w[k*W +: W], wexp(m_deg[k]));
   endtask

   task automatic clear_done();
      @(negedge clk);
      clear = 1'b1;
      #1;
      check("clear_ready_low", er, 0);
      @(posedge clk);
      #1;
      check("clear_gv", gv, 0);
      check("clear_adj", adj, 0);
      check("clear_w", w, 0);
      @(negedge clk);
      clear = 1'b0;
      #1;
      check("clear_ready", er, 1);
      model_clear();
   endtask

   initial begin
      int n;
      logic [15:0] row;
      clear = 0; ev = 0; es = 0; ed = 0; el = 0;
      clear16 = 0; ev16 = 0; es16 = 0; ed16 = 0; el16 = 0;
      model_clear();
      repeat (2) @(negedge clk);
      check("rst_adj", adj, 0);
      check("rst_w", w, 0);
      check("rst_gv", gv, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      #1;
      check("rst_ready", er, 1);

      // Test-plan graph
      send(0, 1, 0, 0); send(0, 2, 0, 0); send(0, 3, 0, 0); send(1, 2, 0, 0);
      send(1, 3, 0, 0); send(2, 0, 0, 0); send(3, 0, 0, 0); send(3, 2, 1, 0);
      wait_valid(1'b0);
      check_graph();
      check("tp1_adj", adj, 16'h3B1C);
      check("tp1_w", w, 64'h8000_FFFF_8000_5555);
      clear_done();

      // Duplicate and self-loop, with backpressure held through DIV/DONE
      send(1, 2, 0, 0); send(1, 2, 0, 1); send(3, 3, 0, 0); send(1, 0, 1, 0);
      wait_valid(1'b1);
      check_graph();
      check("dup_adj", adj, 16'h0202);
      check("dup_w", w, 64'h0000_0000_8000_0000);
      clear_done();

      // clear collides with an offered edge in LOAD
      send(0, 1, 0, 0); send(2, 3, 0, 0);
      @(negedge clk);
      es = 2'd3; ed = 2'd1; el = 1'b0; ev = 1'b1; clear = 1'b1;
      #1;
      check("clr_load_ready", er, 0);
      @(posedge clk);
      #1;
      clear = 1'b0; ev = 1'b0;
      check("clr_load_adj", adj, 0);
      model_clear();
      send(1, 0, 1, 0);
      wait_valid(1'b0);
      check_graph();
      clear_done();

      // Reset ten cycles into DIV
      send(0, 1, 0, 0); send(0, 2, 0, 0); send(1, 3, 1, 0);
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      ev = 1'b0;
      #1;
      check("mid_rst_adj", adj, 0);
      check("mid_rst_w", w, 0);
      check("mid_rst_gv", gv, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      #1;
      check("mid_rst_ready", er, 1);
      send(0, 1, 1, 0);
      wait_valid(1'b0);
      check_graph();
      check("mid_rst_w0", w[15:0], 16'hFFFF);
      clear_done();

      // Random graphs
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            send($urandom_range(0, 3), $urandom_range(0, 3), i == n - 1, $urandom_range(0, 2));
         end
         wait_valid(1'($urandom_range(0, 1)));
         check_graph();
         clear_done();
      end

      // Default N=16: node 0 fans out to all others
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         es16 = 4'd0; ed16 = 4'(k); el16 = (k == 15); ev16 = 1'b1;
         #1;
         check("n16_ready", er16, 1);
         @(posedge clk);
      end
      begin
         int cnt = 0;
         #1;
         ev16 = 1'b0;
         do begin
            @(posedge clk);
            #1;
            cnt++;
         end while (!gv16 && cnt < 2000);
         check("n16_latency", cnt, 272);
      end
      check("n16_w0", w16[15:0], 16'h1111);
      for (int k = 1; k < 16; k++) check($sformatf("n16_w%0d", k), w16[k*W +: W], 0);
      for (int d = 0; d < 16; d++) begin
         row = (d != 0) ? 16'h0001 : 16'h0000;
         check($sformatf("n16_adj_row%0d", d), adj16[d*16 +: 16], row);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
